// File: rtl/digit_argmax_pkg.sv
`default_nettype none
// ============================================================================
// Module   : digit_argmax_pkg
// Purpose  : Shared constants and types for the digit arg-max classifier.
// Revision : 1.0 - initial release
// ============================================================================
package digit_argmax_pkg;

  // Network geometry: ten digit classes, 4-bit unsigned activations.
  localparam int NUM_DIGITS = 10;
  localparam int WEIGHT_W   = 4;
  localparam int IDX_W      = 4;

  // One activation; bit 0 is the MSB, matching the upstream weight bus.
  typedef logic [0:WEIGHT_W-1] weight_t;

  // Digit index, wide enough for 0..NUM_DIGITS-1.
  typedef logic [IDX_W-1:0] digit_idx_t;

  // Whole activation bus as seen on the port and in the snapshot.
  typedef logic [0:NUM_DIGITS-1][0:WEIGHT_W-1] weight_bus_t;

  // Index of the final element; the scan commits when it reaches this.
  localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : digit_argmax_pkg
`default_nettype wire

// File: rtl/digit_argmax.sv
`default_nettype none
// ============================================================================
// Module   : digit_argmax
// Purpose  : Snapshots ten digit activations on start, scans one per clock,
//            and reports the winning digit, its activation, the margin over
//            the runner-up and an ambiguity flag.
// Revision : 1.0 - initial release
// ============================================================================
module digit_argmax
  import digit_argmax_pkg::*;
#(
  parameter int MIN_MARGIN = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  weight_bus_t digit_weights,
  output logic        busy,
  output logic        done,
  output logic        result_valid,
  output digit_idx_t  best_digit,
  output weight_t     best_value,
  output weight_t     margin,
  output logic        ambiguous
);

  // Threshold expressed in the activation width so the compare is same-width.
  localparam weight_t MIN_MARGIN_W = weight_t'(MIN_MARGIN);

  state_t      state;
  state_t      state_next;

  // Start is honoured only from IDLE or DONE; last marks the commit edge.
  logic        accept;
  logic        last;

  // Frozen copy of the weights and the running scan trackers.
  weight_bus_t snapshot;
  digit_idx_t  idx;
  weight_t     best;
  weight_t     second;
  digit_idx_t  best_idx;

  // Tracker values after folding in the element at idx.
  weight_t     cur_weight;
  weight_t     best_upd;
  weight_t     second_upd;
  digit_idx_t  best_idx_upd;
  weight_t     margin_upd;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; start is ignored while scanning.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SCAN;
          accept     = 1'b1;
        end
      end
      SCAN: begin
        if (idx == LAST_IDX) begin
          state_next = DONE;
          last       = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_next = SCAN;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // busy covers the scan cycles; done is the single DONE-state cycle.
  assign busy = (state == SCAN);
  assign done = (state == DONE);

  // Compare/update step: strict greater-than keeps the lowest index on ties
  // and lets a duplicated maximum land in second, giving margin zero.
  always_comb begin
    cur_weight   = snapshot[idx];
    best_upd     = best;
    second_upd   = second;
    best_idx_upd = best_idx;
    if (cur_weight > best) begin
      second_upd   = best;
      best_upd     = cur_weight;
      best_idx_upd = idx;
    end else if (cur_weight > second) begin
      second_upd   = cur_weight;
    end
    margin_upd = best_upd - second_upd;
  end

  // Snapshot, scan trackers and committed result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      snapshot     <= '0;
      idx          <= '0;
      best         <= '0;
      second       <= '0;
      best_idx     <= '0;
      result_valid <= 1'b0;
      best_digit   <= '0;
      best_value   <= '0;
      margin       <= '0;
      ambiguous    <= 1'b0;
    end else if (accept) begin
      snapshot     <= digit_weights;
      idx          <= '0;
      best         <= '0;
      second       <= '0;
      best_idx     <= '0;
      result_valid <= 1'b0;
    end else if (state == SCAN) begin
      best     <= best_upd;
      second   <= second_upd;
      best_idx <= best_idx_upd;
      if (last) begin
        // Index parks at the last element rather than wrapping.
        best_digit   <= best_idx_upd;
        best_value   <= best_upd;
        margin       <= margin_upd;
        ambiguous    <= (margin_upd < MIN_MARGIN_W);
        result_valid <= 1'b1;
      end else begin
        idx <= idx + digit_idx_t'(1);
      end
    end
  end

endmodule : digit_argmax
`default_nettype wire

// File: tb/tb_digit_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_argmax
// Purpose  : Self-checking bench for digit_argmax against an arg-max model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_argmax;
  import digit_argmax_pkg::*;

  typedef logic [3:0] wvec_t [NUM_DIGITS];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  weight_bus_t digit_weights = '0;
  logic        busy;
  logic        done;
  logic        result_valid;
  digit_idx_t  best_digit;
  weight_t     best_value;
  weight_t     margin;
  logic        ambiguous;

  int n_checks = 0;
  int n_fail   = 0;

  digit_argmax #(
    .MIN_MARGIN (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .digit_weights (digit_weights),
    .busy          (busy),
    .done          (done),
    .result_valid  (result_valid),
    .best_digit    (best_digit),
    .best_value    (best_value),
    .margin        (margin),
    .ambiguous     (ambiguous)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if it disagrees.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: first index holding the maximum; runner-up is the largest of
  // the remaining elements.
  function automatic void model(input wvec_t w, output int bd, output int bv,
                                output int mg, output int amb);
    int sec;
    bd  = 0;
    bv  = -1;
    sec = 0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (int'(w[k]) > bv) begin
        bv = int'(w[k]);
        bd = k;
      end
    for (int k = 0; k < NUM_DIGITS; k++)
      if (k != bd && int'(w[k]) > sec) sec = int'(w[k]);
    mg  = bv - sec;
    amb = (mg < 2) ? 1 : 0;
  endfunction

  task automatic set_weights(input wvec_t w);
    for (int k = 0; k < NUM_DIGITS; k++) digit_weights[k] = w[k];
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":done"}, done, 0);
    check({tag, ":rv"}, result_valid, 0);
    check({tag, ":bd"}, best_digit, 0);
    check({tag, ":bv"}, best_value, 0);
    check({tag, ":mg"}, margin, 0);
    check({tag, ":amb"}, ambiguous, 0);
  endtask

  // Issue one start and follow it to done. mode 0: quiet inputs;
  // mode 1: random weights and start toggling during the scan;
  // mode 2: all-15 weights plus a start pulse at scan cycle 4.
  // Returns at the negedge of the done cycle.
  task automatic run_case(input string tag, input wvec_t w, input int mode);
    int ebd, ebv, emg, eamb;
    int k, busy_cycles;
    model(w, ebd, ebv, emg, eamb);
    set_weights(w);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ":busy0"}, busy, 1);
    check({tag, ":rvclr"}, result_valid, 0);
    k = 1;
    busy_cycles = 1;
    while (!done && k < 40) begin
      if (mode == 1) begin
        for (int j = 0; j < NUM_DIGITS; j++) digit_weights[j] = 4'($urandom_range(0, 15));
        start = 1'($urandom_range(0, 1));
      end else if (mode == 2 && k == 4) begin
        digit_weights = '1;
        start = 1'b1;
      end else if (mode == 2 && k == 5) begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
      if (busy) busy_cycles++;
    end
    start = 1'b0;
    check({tag, ":latency"}, k, 11);
    check({tag, ":busycyc"}, busy_cycles, 10);
    check({tag, ":busydone"}, busy, 0);
    check({tag, ":rv"}, result_valid, 1);
    check({tag, ":bd"}, best_digit, ebd);
    check({tag, ":bv"}, best_value, ebv);
    check({tag, ":mg"}, margin, emg);
    check({tag, ":amb"}, ambiguous, eamb);
  endtask

  initial begin
    wvec_t w;
    int    dones;
    int    gap;

    // Reset held with start and weights active.
    reset = 1'b1;
    start = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) digit_weights[k] = 4'($urandom_range(0, 15));
    repeat (2) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle:busy", busy, 0);

    // Nominal ascending weights.
    w = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15};
    run_case("nom", w, 0);
    check("nom:bd9", best_digit, 9);
    check("nom:mg6", margin, 6);
    repeat (3) @(negedge clk);
    check("hold:done", done, 0);
    check("hold:rv", result_valid, 1);
    check("hold:bv", best_value, 15);

    // Tie between digits 3 and 7.
    w = '{4'd0, 4'd0, 4'd0, 4'd12, 4'd0, 4'd0, 4'd0, 4'd12, 4'd0, 4'd0};
    run_case("tie", w, 0);
    check("tie:bd3", best_digit, 3);
    @(negedge clk);

    // Snapshot isolation and ignored mid-scan start.
    w = '{4'd0, 4'd0, 4'd14, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3};
    run_case("snap", w, 2);
    check("snap:mg11", margin, 11);
    @(negedge clk);
    check("snap:single_done", done, 0);
    check("snap:idle", busy, 0);

    // Reset at scan cycle 5 aborts without a done pulse.
    for (int k = 0; k < NUM_DIGITS; k++) w[k] = 4'($urandom_range(0, 15));
    set_weights(w);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero("midrst");
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst:nodone", dones, 0);

    // Fresh start after abort, then back-to-back all-zero in the DONE cycle.
    w = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd8, 4'd7, 4'd0, 4'd0, 4'd0};
    run_case("fresh", w, 0);
    w = '{default: 4'd0};
    run_case("b2b_zero", w, 0);
    check("zero:amb", ambiguous, 1);

    // Randomized cases with random gaps, including back-to-back and ties.
    for (int n = 0; n < 25; n++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 1) == 1)
        for (int k = 0; k < NUM_DIGITS; k++) w[k] = 4'($urandom_range(0, 3));
      else
        for (int k = 0; k < NUM_DIGITS; k++) w[k] = 4'($urandom_range(0, 15));
      run_case($sformatf("rnd%0d", n), w, int'($urandom_range(0, 1)));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_digit_argmax
`default_nettype wire
